// File: rtl/trinity_link_pkg.sv
// trinity_link_pkg: shared constants, header field slices and FSM states for the link receiver
package trinity_link_pkg;

    localparam logic [7:0] SOF = 8'hA5;
    localparam int LEN_MSB = 3;
    localparam int LEN_LSB = 0;
    localparam int TAG_MSB = 7;
    localparam int TAG_LSB = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_CSUM,
        S_DROP
    } state_e;

endpackage

// File: rtl/trinity_link_fifo.sv
// trinity_link_fifo: 9-bit FIFO whose writes stay invisible to the reader until committed
module trinity_link_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [8:0]  wr_data,
    input  logic        commit,
    input  logic        rollback,
    input  logic        rd_en,
    output logic [8:0]  rd_data,
    output logic [AW:0] free_count,
    output logic        valid
);

    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_spec_q;
    logic [AW:0] wr_commit_q;
    logic [AW:0] rd_q;

    // payload storage, written speculatively at wr_spec
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_spec_q[AW-1:0]] <= wr_data;
    end

    // speculative, committed and read pointers; rollback rewinds to the last commit
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            rd_q        <= '0;
        end else begin
            if (wr_en) wr_spec_q <= wr_spec_q + 1'b1;
            else if (rollback) wr_spec_q <= wr_commit_q;
            if (commit) wr_commit_q <= wr_spec_q;
            if (rd_en && valid) rd_q <= rd_q + 1'b1;
        end
    end

    assign valid      = wr_commit_q != rd_q;
    assign rd_data    = valid ? mem_q[rd_q[AW-1:0]] : '0;
    assign free_count = (AW+1)'(DEPTH) - (wr_spec_q - rd_q);

endmodule

// File: rtl/trinity_link_rx.sv
// trinity_link_rx: frames the neighbour link byte stream and releases only checksum-clean payloads
module trinity_link_rx
    import trinity_link_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN    = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] link_in,
    output logic [7:0] rx_data,
    output logic       rx_last,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] frame_ok_cnt,
    output logic [7:0] frame_err_cnt,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_e      state_q, state_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  xor_q, xor_d;
    logic [7:0]  ok_q, err_q;
    logic        wr_en, commit, rollback, ok_inc, err_inc;
    logic [3:0]  hdr_len;
    logic [8:0]  rd_data;
    logic [AW:0] free_count;

    assign hdr_len = link_in[LEN_MSB:LEN_LSB];

    trinity_link_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .wr_en      (wr_en),
        .wr_data    ({cnt_q == len_q, link_in}),
        .commit     (commit),
        .rollback   (rollback),
        .rd_en      (rx_ready),
        .rd_data    (rd_data),
        .free_count (free_count),
        .valid      (rx_valid)
    );

    // state, frame bookkeeping and saturating frame counters
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            xor_q   <= '0;
            ok_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
            if (ok_inc && ok_q != 8'hFF) ok_q <= ok_q + 1'b1;
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 1'b1;
        end
    end

    // frame parser: header validation, space check, payload write and checksum verdict
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        xor_d    = xor_q;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        ok_inc   = 1'b0;
        err_inc  = 1'b0;
        case (state_q)
            S_IDLE: if (link_in == SOF) state_d = S_HDR;
            S_HDR: begin
                len_d = hdr_len;
                if (hdr_len == 4'd0 || int'(hdr_len) > MAX_LEN) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else if (int'(free_count) < int'(hdr_len)) begin
                    err_inc = 1'b1;
                    cnt_d   = hdr_len;
                    state_d = S_DROP;
                end else begin
                    cnt_d   = 4'd1;
                    xor_d   = link_in;
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                wr_en = 1'b1;
                xor_d = xor_q ^ link_in;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == len_q) state_d = S_CSUM;
            end
            S_CSUM: begin
                commit   = link_in == xor_q;
                rollback = !commit;
                ok_inc   = commit;
                err_inc  = rollback;
                state_d  = S_IDLE;
            end
            S_DROP: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 4'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_data       = rd_data[7:0];
    assign rx_last       = rd_data[8];
    assign frame_ok_cnt  = ok_q;
    assign frame_err_cnt = err_q;
    assign busy          = state_q != S_IDLE;

endmodule

// File: tb/tb_trinity_link_rx.sv
// tb_trinity_link_rx: directed frames with a scoreboard queue checked by an independent monitor
module tb_trinity_link_rx;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] link_in = 8'h00;
    logic [7:0] rx_data;
    logic       rx_last;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [7:0] frame_ok_cnt;
    logic [7:0] frame_err_cnt;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int exp_ok = 0;
    int exp_err = 0;
    logic [8:0] exp_q [$];

    trinity_link_rx #(.FIFO_DEPTH(16), .MAX_LEN(8)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .link_in       (link_in),
        .rx_data       (rx_data),
        .rx_last       (rx_last),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt),
        .busy          (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // head byte is compared every cycle it is presented; popped only when it transfers
    always @(negedge sys_clk) begin
        if (!sys_rst && rx_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", {23'd0, rx_last, rx_data}, 32'h1FF);
            end else begin
                check("rx_byte", {23'd0, rx_last, rx_data}, {23'd0, exp_q[0]});
                if (rx_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk);
        #1 link_in = b;
    endtask

    task automatic settle();
        @(posedge sys_clk);
        #1 link_in = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input int n, input logic [127:0] d,
                              input logic [7:0] cs, input bit good);
        if (good) for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, d[8*i +: 8]});
        send_byte(8'hA5);
        send_byte(hdr);
        for (int i = 0; i < n; i++) send_byte(d[8*i +: 8]);
        send_byte(cs);
        settle();
        if (good) exp_ok++;
        else exp_err++;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_ok_cnt"}, {24'd0, frame_ok_cnt}, exp_ok);
        check({tag, "_err_cnt"}, {24'd0, frame_err_cnt}, exp_err);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge sys_clk);
        #1;
        check({tag, "_drain_left"}, exp_q.size(), 0);
        @(posedge sys_clk);
        #1;
        check({tag, "_valid_after_drain"}, {31'd0, rx_valid}, 0);
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        link_in = 8'h00;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        exp_q.delete();
        exp_ok = 0;
        exp_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_data", {24'd0, rx_data}, 0);
        check("rst_last", {31'd0, rx_last}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check_counts("rst");

        for (int i = 0; i < 20; i++) send_byte(i[0] ? 8'h55 : 8'h00);
        settle();
        check("idle_valid", {31'd0, rx_valid}, 0);
        check("idle_busy", {31'd0, busy}, 0);
        check_counts("idle");

        send_frame(8'h03, 3, 128'h332211, 8'h03, 1'b1);
        check("good_latency_valid", {31'd0, rx_valid}, 1);
        check_counts("good");
        wait_drain("good");

        send_frame(8'h03, 3, 128'h332211, 8'h04, 1'b0);
        check("badcs_valid", {31'd0, rx_valid}, 0);
        check_counts("badcs");
        send_frame(8'h02, 2, 128'hBBAA, 8'h13, 1'b1);
        wait_drain("rollback");
        check_counts("rollback");

        send_frame(8'h02, 2, 128'h01A5, 8'hA6, 1'b1);
        wait_drain("sof_data");

        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'hA5); send_byte(8'h0F); send_byte(8'h33); send_byte(8'h44);
        settle();
        exp_err += 2;
        check_counts("badlen");
        check("badlen_busy", {31'd0, busy}, 0);
        check("badlen_valid", {31'd0, rx_valid}, 0);

        rx_ready = 1'b0;
        send_frame(8'h08, 8, 128'h0807060504030201, 8'h00, 1'b1);
        send_frame(8'h18, 8, 128'h100F0E0D0C0B0A09, 8'h00, 1'b1);
        send_frame(8'h01, 1, 128'h77, 8'h76, 1'b0);
        check("drop_busy", {31'd0, busy}, 0);
        check_counts("drop");
        check("full_queue", exp_q.size(), 16);
        rx_ready = 1'b1;
        wait_drain("full");

        rx_ready = 1'b0;
        send_frame(8'h05, 5, 128'h0504030201, 8'h04, 1'b1);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
        do_reset();
        check("midrst_valid", {31'd0, rx_valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check_counts("midrst");
        rx_ready = 1'b1;
        send_frame(8'h01, 1, 128'h5A, 8'h5B, 1'b1);
        wait_drain("post_rst");
        check_counts("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
